// File: rtl/if_xfer_sched.sv
// Round-robin scheduler that shares one IF port between NUM_REQ requesters.
// Per transaction: grant, cfg handshake, gated beat transfer to programmed length, done pulse.
module if_xfer_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned PORT_WIDTH = 128,
    parameter int unsigned LEN_WIDTH  = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_val,
    input  logic [NUM_REQ*4-1:0]            req_info,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic [NUM_REQ-1:0]              req_gnt,
    output logic [NUM_REQ-1:0]              req_done,
    output logic                            cfg_val,
    input  logic                            cfg_rdy,
    output logic [3:0]                      cfg_info,
    input  logic [NUM_REQ-1:0]              cli_wr_val,
    input  logic [NUM_REQ*PORT_WIDTH-1:0]   cli_wr_data,
    output logic [NUM_REQ-1:0]              cli_wr_rdy,
    output logic                            if_wr_val,
    output logic [PORT_WIDTH-1:0]           if_wr_data,
    input  logic                            if_wr_rdy,
    input  logic                            if_rd_val,
    output logic [NUM_REQ-1:0]              cli_rd_val,
    input  logic [NUM_REQ-1:0]              cli_rd_rdy,
    output logic                            if_rd_rdy,
    output logic                            busy
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StCfg, StXfer, StDone} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [3:0]           info_q, info_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

    logic                 pick_found;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IdxW-1:0]      pick_idx;
    logic [3:0]           pick_info;
    logic [LEN_WIDTH-1:0] pick_len;
    logic                 beat;
    logic                 rw;

    assign rw = info_q[0];

    // Rotating priority search: first pending request at or above rr_ptr, with wrap.
    always_comb begin
        int unsigned j;
        j          = 0;
        pick_found = 1'b0;
        pick_oh    = '0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = 32'(rr_ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!pick_found && (k == j) && req_val[k]) begin
                    pick_found = 1'b1;
                    pick_oh[k] = 1'b1;
                    pick_idx   = IdxW'(k);
                end
            end
        end
    end

    always_comb begin
        pick_info = '0;
        pick_len  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_info = pick_info | req_info[i*4 +: 4];
                pick_len  = pick_len | req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            info_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            info_q   <= info_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        info_d   = info_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StCfg;
                    gnt_d   = pick_oh;
                    gidx_d  = pick_idx;
                    info_d  = pick_info;
                    len_d   = pick_len;
                end
            end
            StCfg: begin
                if (cfg_rdy) begin
                    state_d = StXfer;
                    cnt_d   = '0;
                end
            end
            StXfer: begin
                if (beat) begin
                    // Exit on the last beat so the counter never needs to wrap.
                    if (cnt_q == len_q) begin
                        state_d = StDone;
                        gnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d  = StIdle;
                rr_ptr_d = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: beat gating is purely combinational and only open in XFER.
    always_comb begin
        req_gnt    = gnt_q;
        req_done   = '0;
        cfg_val    = (state_q == StCfg);
        cfg_info   = info_q;
        busy       = (state_q != StIdle);
        cli_wr_rdy = '0;
        if_wr_val  = 1'b0;
        if_wr_data = '0;
        cli_rd_val = '0;
        if_rd_rdy  = 1'b0;
        beat       = 1'b0;
        if (state_q == StDone) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_done[i] = (gidx_q == IdxW'(i));
            end
        end
        if (state_q == StXfer) begin
            if (!rw) begin
                cli_wr_rdy = gnt_q & {NUM_REQ{if_wr_rdy}};
                if_wr_val  = |(gnt_q & cli_wr_val);
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (gnt_q[i]) begin
                        if_wr_data = if_wr_data | cli_wr_data[i*PORT_WIDTH +: PORT_WIDTH];
                    end
                end
                beat = if_wr_val & if_wr_rdy;
            end else begin
                cli_rd_val = gnt_q & {NUM_REQ{if_rd_val}};
                if_rd_rdy  = |(gnt_q & cli_rd_rdy);
                beat       = if_rd_val & if_rd_rdy;
            end
        end
    end

endmodule
